// File: rtl/csr_unit_if.sv
// CSR access port between the core pipeline and csr_unit.
// Carries software read/write and trap-entry signals.
interface csr_if;
    logic        csr_write;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_exception;
    logic [31:0] csr_exception_cause;
    logic [31:0] csr_exception_pc;
    logic        csr_mie;

    modport csr (
        input  csr_write,
        input  csr_waddr,
        input  csr_wdata,
        input  csr_raddr,
        output csr_rdata,
        input  csr_exception,
        input  csr_exception_cause,
        input  csr_exception_pc,
        output csr_mie
    );

    modport core (
        output csr_write,
        output csr_waddr,
        output csr_wdata,
        output csr_raddr,
        input  csr_rdata,
        output csr_exception,
        output csr_exception_cause,
        output csr_exception_pc,
        input  csr_mie
    );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR file for an RV32I hart.
// Trap entry takes priority over software writes.
module csr_unit #(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input logic clk,
    input logic rst,
    csr_if.csr  cif
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    localparam logic [31:0] MISA_VAL = 32'h4000_0100;

    logic        st_mie;
    logic        st_mpie;
    logic        ie_msie;
    logic        ie_mtie;
    logic        ie_meie;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [63:0] mcycle;

    logic        sw_we;
    logic [31:0] wdata;
    logic [11:0] waddr;

    // A trap in the same cycle drops the software write entirely.
    assign sw_we = cif.csr_write & ~cif.csr_exception;
    assign wdata = cif.csr_wdata;
    assign waddr = cif.csr_waddr;

    assign cif.csr_mie = st_mie;

    // mstatus interrupt-enable stack: trap entry or software write.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_mie  <= 1'b0;
            st_mpie <= 1'b0;
        end else if (cif.csr_exception) begin
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
        end else if (sw_we && waddr == A_MSTATUS) begin
            st_mie  <= wdata[3];
            st_mpie <= wdata[7];
        end
    end

    // Trap-state registers mepc/mcause: trap entry overrides writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            mepc   <= 32'd0;
            mcause <= 32'd0;
        end else if (cif.csr_exception) begin
            mepc   <= cif.csr_exception_pc & ~32'd3;
            mcause <= cif.csr_exception_cause;
        end else if (sw_we) begin
            if (waddr == A_MEPC)   mepc   <= wdata & ~32'd3;
            if (waddr == A_MCAUSE) mcause <= wdata;
        end
    end

    // Plain software-writable registers: mie, mtvec, mscratch.
    always_ff @(posedge clk) begin
        if (rst) begin
            ie_msie  <= 1'b0;
            ie_mtie  <= 1'b0;
            ie_meie  <= 1'b0;
            mtvec    <= MTVEC_RESET & ~32'd3;
            mscratch <= 32'd0;
        end else if (sw_we) begin
            unique case (waddr)
                A_MIE: begin
                    ie_msie <= wdata[3];
                    ie_mtie <= wdata[7];
                    ie_meie <= wdata[11];
                end
                A_MTVEC:    mtvec    <= wdata & ~32'd3;
                A_MSCRATCH: mscratch <= wdata;
                default: ;
            endcase
        end
    end

    // Free-running cycle counter; a half write replaces that cycle's increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle <= 64'd0;
        end else if (sw_we && waddr == A_MCYCLE) begin
            mcycle <= {mcycle[63:32], wdata};
        end else if (sw_we && waddr == A_MCYCLEH) begin
            mcycle <= {wdata, mcycle[31:0]};
        end else begin
            mcycle <= mcycle + 64'd1;
        end
    end

    // Combinational read mux; unimplemented addresses read zero.
    always_comb begin
        cif.csr_rdata = 32'd0;
        unique case (cif.csr_raddr)
            A_MSTATUS:  cif.csr_rdata = {19'd0, 2'b11, 3'd0, st_mpie,
                                         3'd0, st_mie, 3'd0};
            A_MISA:     cif.csr_rdata = MISA_VAL;
            A_MIE:      cif.csr_rdata = {20'd0, ie_meie, 3'd0, ie_mtie,
                                         3'd0, ie_msie, 3'd0};
            A_MTVEC:    cif.csr_rdata = mtvec;
            A_MSCRATCH: cif.csr_rdata = mscratch;
            A_MEPC:     cif.csr_rdata = mepc;
            A_MCAUSE:   cif.csr_rdata = mcause;
            A_MIP:      cif.csr_rdata = 32'd0;
            A_MCYCLE:   cif.csr_rdata = mcycle[31:0];
            A_MCYCLEH:  cif.csr_rdata = mcycle[63:32];
            A_MHARTID:  cif.csr_rdata = HART_ID;
            default:    cif.csr_rdata = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit with an expected-value queue.
// Inputs change 1 time unit after each rising edge.
module tb_csr_unit;
    localparam logic [31:0] HART  = 32'd5;
    localparam logic [31:0] TVEC0 = 32'h0000_1003;

    logic clk;
    logic rst;
    csr_if cif ();

    csr_unit #(
        .HART_ID     (HART),
        .MTVEC_RESET (TVEC0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .cif (cif.csr)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h",
                       e.tag, obs, e.val);
            end
        end
    endtask

    task automatic rd(input string tag, input logic [11:0] a,
                      input logic [31:0] v);
        exp_q.push_back('{tag, v});
        cif.csr_raddr = a;
        #1;
        compare(cif.csr_rdata);
    endtask

    task automatic chk_mie(input string tag, input logic v);
        exp_q.push_back('{tag, {31'd0, v}});
        #1;
        compare({31'd0, cif.csr_mie});
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        cif.csr_write = 1'b1;
        cif.csr_waddr = a;
        cif.csr_wdata = d;
    endtask

    task automatic idle();
        cif.csr_write     = 1'b0;
        cif.csr_exception = 1'b0;
    endtask

    initial begin
        rst                     = 1'b1;
        cif.csr_write           = 1'b0;
        cif.csr_waddr           = 12'h000;
        cif.csr_wdata           = 32'd0;
        cif.csr_raddr           = 12'h000;
        cif.csr_exception       = 1'b0;
        cif.csr_exception_cause = 32'd0;
        cif.csr_exception_pc    = 32'd0;

        step();
        step();
        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        rd("rst_mie", 12'h304, 32'd0);
        rd("rst_mepc", 12'h341, 32'd0);
        rd("rst_mcause", 12'h342, 32'd0);
        rd("rst_mcycle", 12'hB00, 32'd0);
        rd("rst_mhartid", 12'hF14, HART);
        rd("rst_unimpl", 12'h7C0, 32'd0);
        rd("rst_mtvec", 12'h305, 32'h0000_1000);
        rd("rst_mscratch", 12'h340, 32'd0);
        rd("misa", 12'h301, 32'h4000_0100);
        rd("mip", 12'h344, 32'd0);
        chk_mie("rst_csr_mie", 1'b0);

        rst = 1'b0;
        step();
        rd("mcycle_first", 12'hB00, 32'd1);
        rd("mcycleh_first", 12'hB80, 32'd0);

        wr(12'h300, 32'hFFFF_FFFF);
        rd("mstatus_nobypass", 12'h300, 32'h0000_1800);
        chk_mie("csr_mie_before", 1'b0);
        step();
        idle();
        rd("mstatus_wr", 12'h300, 32'h0000_1888);
        chk_mie("csr_mie_set", 1'b1);

        wr(12'h305, 32'h8000_0103);
        step();
        wr(12'h304, 32'hFFFF_FFFF);
        rd("mtvec_wr", 12'h305, 32'h8000_0100);
        step();
        wr(12'h340, 32'hA5A5_0000);
        rd("mie_wr", 12'h304, 32'h0000_0888);
        rd("mscratch_old", 12'h340, 32'd0);
        step();
        wr(12'h7C0, 32'h1234_5678);
        rd("mscratch_new", 12'h340, 32'hA5A5_0000);
        step();
        wr(12'h301, 32'd0);
        rd("unimpl_wr", 12'h7C0, 32'd0);
        step();
        wr(12'h341, 32'h0000_2223);
        rd("misa_ro", 12'h301, 32'h4000_0100);
        step();
        idle();
        rd("mepc_wr", 12'h341, 32'h0000_2220);

        wr(12'h340, 32'd5);
        cif.csr_exception       = 1'b1;
        cif.csr_exception_cause = 32'h8000_000B;
        cif.csr_exception_pc    = 32'h0000_1236;
        step();
        idle();
        rd("trap_mepc", 12'h341, 32'h0000_1234);
        rd("trap_mcause", 12'h342, 32'h8000_000B);
        rd("trap_mstatus", 12'h300, 32'h0000_1880);
        rd("trap_mscratch", 12'h340, 32'hA5A5_0000);
        chk_mie("trap_csr_mie", 1'b0);

        wr(12'h342, 32'd7);
        step();
        idle();
        rd("b2b_mcause_wr", 12'h342, 32'd7);
        cif.csr_exception       = 1'b1;
        cif.csr_exception_cause = 32'd3;
        cif.csr_exception_pc    = 32'd8;
        step();
        idle();
        rd("b2b_trap_cause", 12'h342, 32'd3);
        rd("b2b_trap_pc", 12'h341, 32'd8);
        rd("b2b_mstatus", 12'h300, 32'h0000_1800);

        wr(12'hB00, 32'hFFFF_FFFF);
        step();
        wr(12'hB80, 32'd0);
        rd("mcycle_load", 12'hB00, 32'hFFFF_FFFF);
        step();
        idle();
        rd("mcycle_hold", 12'hB00, 32'hFFFF_FFFF);
        rd("mcycleh_load", 12'hB80, 32'd0);
        step();
        rd("mcycleh_carry", 12'hB80, 32'd1);
        rd("mcycle_wrap", 12'hB00, 32'd0);

        wr(12'h300, 32'h0000_0008);
        step();
        idle();
        chk_mie("csr_mie_reen", 1'b1);
        rst = 1'b1;
        wr(12'h304, 32'hFFFF_FFFF);
        step();
        rst = 1'b0;
        idle();
        rd("midrst_mie", 12'h304, 32'd0);
        rd("midrst_mcycle", 12'hB00, 32'd0);
        rd("midrst_mtvec", 12'h305, 32'h0000_1000);
        rd("midrst_mscratch", 12'h340, 32'd0);
        chk_mie("midrst_csr_mie", 1'b0);
        step();
        rd("midrst_resume", 12'hB00, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 SHALL have parameter HART_ID, default 0, returned by mhartid (0xF14).
REQ-002 SHALL have parameter MTVEC_RESET, default 32'h0000_0000, mtvec reset value, bits[1:0] forced 0.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cif  csr_if.csr modport  --  carries the signals in REQ-006..REQ-013.
REQ-006 SHALL take csr_write  input  1  software write strobe.
REQ-007 SHALL take csr_waddr  input  12  write CSR address.
REQ-008 SHALL take csr_wdata  input  32  write data, already resolved by the core for CSRRS/CSRRC.
REQ-009 SHALL take csr_raddr  input  12  read CSR address.
REQ-010 SHALL drive csr_rdata  output  32  read data.
REQ-011 SHALL take csr_exception  input  1  trap-entry strobe.
REQ-012 SHALL take csr_exception_cause / csr_exception_pc  input  32 each  trap cause and faulting PC.
REQ-013 SHALL drive csr_mie  output  1  registered copy of mstatus.MIE.

Function
REQ-014 SHALL implement: mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344, mcycle 0xB00, mcycleh 0xB80, mhartid 0xF14.
REQ-015 SHALL return csr_rdata combinationally from csr_raddr and current register state; no write-to-read bypass (same-cycle read of a written CSR returns the old value).
REQ-016 SHALL return 0 on reads of unimplemented addresses and ignore writes to them.
REQ-017 mstatus: only MIE (bit 3) and MPIE (bit 7) writable; MPP bits[12:11] read 2'b11; all other bits read 0.
REQ-018 misa SHALL read 32'h4000_0100 (RV32I); misa, mhartid, mip read-only, mip reads 0.
REQ-019 mie: only MSIE(3), MTIE(7), MEIE(11) writable, other bits read 0.
REQ-020 mtvec and mepc: bits[1:0] SHALL be forced to 0 on every update (direct mode, aligned).
REQ-021 mscratch, mcause: full 32-bit read/write.
REQ-022 mcycle: 64-bit counter, +1 every cycle not in reset; wraps 2^64-1 -> 0; mcycle/mcycleh expose low/high halves.
REQ-023 A write to mcycle (mcycleh) SHALL load the written half, keep the other half unchanged, and suppress that cycle's increment.
REQ-024 On csr_exception=1 at an edge: mepc <= csr_exception_pc & ~3; mcause <= csr_exception_cause; MPIE <= MIE; MIE <= 0.
REQ-025 When csr_exception and csr_write coincide, the exception update SHALL win and the software write SHALL be dropped entirely (mcycle still increments).
REQ-026 csr_mie SHALL equal mstatus.MIE as registered (updates one cycle after the causing write/exception).
REQ-027 Back-to-back writes/exceptions on consecutive cycles SHALL each take effect; no stall or handshake exists.

Reset
REQ-028 With rst=1 at an edge: mstatus.MIE=0, MPIE=0, mie=0, mtvec=MTVEC_RESET, mscratch=0, mepc=0, mcause=0, mcycle=0, csr_mie=0.
REQ-029 rst SHALL override any concurrent csr_write or csr_exception; counting resumes the first edge after rst deasserts (mcycle=1 one cycle later).
REQ-030 csr_rdata SHALL reflect reset values in the cycle after the reset edge.

Verification
REQ-031 Reset then read 0x300,0x304,0x341,0x342,0xB00 -> 32'h0000_1800, 0, 0, 0, 0; read 0xF14 -> HART_ID; read 0x7C0 -> 0.
REQ-032 Write 0x300 <= 32'hFFFF_FFFF -> read 32'h0000_1888, csr_mie=1 next cycle; write 0x305 <= 32'h8000_0103 -> read 32'h8000_0100.
REQ-033 With MIE=1, pulse csr_exception, cause=32'h8000_000B, pc=32'h0000_1236, plus csr_write 0x340<=5 same cycle -> mepc=32'h0000_1234, mcause=32'h8000_000B, mstatus=32'h0000_1880, csr_mie=0, mscratch unchanged.
REQ-034 Write mcycle <= 32'hFFFF_FFFF, mcycleh <= 0 -> two cycles later read 0xB80=1, 0xB00=0 (carry propagates).
REQ-035 Write 0x340 and read 0x340 same cycle -> old value that cycle, new value next cycle.
REQ-036 Assert rst mid-run with csr_write 0x304 active -> mie=0, mcycle=0 after edge; write not applied.
